// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract with the carry chain split into
// STAGES register stages of CHUNK bits each. Streams one operation per cycle
// under valid/ready; the whole pipe stalls together while the output is held.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  generate
    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_param
      $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end
  endgenerate

  // Per-stage state; index 0 is the first stage, STAGES-1 drives the outputs.
  // a/b carry the operand chunks not yet summed, sum holds finished chunks.
  logic [STAGES-1:0]             vld_q, vld_d;
  logic [STAGES-1:0]             cy_q, cy_d;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0]  b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0]  sum_q, sum_d;
  logic                          ovf_q, ovf_d;

  logic                          adv;
  logic [WIDTH-1:0]              b_eff;
  logic                          c0;
  logic [STAGES-1:0][CHUNK:0]    part;

  // Whole pipe moves whenever the output slot is empty or being drained.
  assign adv      = out_ready | ~vld_q[STAGES-1];
  assign in_ready = adv;

  // Subtract is A + ~B + 1, so the user carry-in is overridden.
  assign b_eff = in_sub ? ~in_b : in_b;
  assign c0    = in_sub | in_cin;

  // Next-state: one chunk of the carry chain resolved per stage.
  always_comb begin
    vld_d = vld_q;
    cy_d  = cy_q;
    a_d   = a_q;
    b_d   = b_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    part  = '0;

    part[0] = {1'b0, in_a[CHUNK-1:0]} + {1'b0, b_eff[CHUNK-1:0]} + {{CHUNK{1'b0}}, c0};
    for (int s = 1; s < STAGES; s++) begin
      part[s] = {1'b0, a_q[s-1][s*CHUNK +: CHUNK]} + {1'b0, b_q[s-1][s*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cy_q[s-1]};
    end

    if (adv) begin
      // Inner stages shift unconditionally; the final stage (which is the
      // output register) only loads real results so it holds the last one.
      vld_d[0] = in_valid;
      if (STAGES > 1 || in_valid) begin
        a_d[0]              = in_a;
        b_d[0]              = b_eff;
        sum_d[0]            = '0;
        sum_d[0][CHUNK-1:0] = part[0][CHUNK-1:0];
        cy_d[0]             = part[0][CHUNK];
      end
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        if (s < STAGES-1 || vld_q[s-1]) begin
          a_d[s]                     = a_q[s-1];
          b_d[s]                     = b_q[s-1];
          sum_d[s]                   = sum_q[s-1];
          sum_d[s][s*CHUNK +: CHUNK] = part[s][CHUNK-1:0];
          cy_d[s]                    = part[s][CHUNK];
        end
      end
      // Carry into the MSB is recovered as a^b^sum at that bit.
      if (vld_d[STAGES-1]) begin
        ovf_d = a_d[STAGES-1][WIDTH-1] ^ b_d[STAGES-1][WIDTH-1]
              ^ sum_d[STAGES-1][WIDTH-1] ^ cy_d[STAGES-1];
      end
    end
  end

  // Stage registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = cy_q[STAGES-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three instances (STAGES 4, 1, 16) share one
// stimulus stream; a result-level model per instance is compared every cycle.
module tb_pipelined_adder;

  localparam int ST [3] = '{4, 1, 16};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_cin, in_sub, out_ready;
  logic [15:0] in_a, in_b;

  logic        iready [3];
  logic        ovalid [3];
  logic        ocout  [3];
  logic        oovf   [3];
  logic [15:0] osum   [3];

  int checks = 0;
  int errors = 0;
  int hs  [3];
  int lat [3];
  int exp_lat [3] = '{3, 0, 15};

  // model: per-instance slots of {valid, result} plus the held output word
  logic        mv [3][16];
  logic [17:0] mr [3][16];
  logic [17:0] mo [3];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[0]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ovalid[0]), .out_ready(out_ready), .out_sum(osum[0]),
    .out_cout(ocout[0]), .out_ovf(oovf[0]));

  pipelined_adder #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[1]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ovalid[1]), .out_ready(out_ready), .out_sum(osum[1]),
    .out_cout(ocout[1]), .out_ovf(oovf[1]));

  pipelined_adder #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[2]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(ovalid[2]), .out_ready(out_ready), .out_sum(osum[2]),
    .out_cout(ocout[2]), .out_ovf(oovf[2]));

  // Reference result {ovf, cout, sum} from plain arithmetic.
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
    logic [16:0] full;
    logic        ov;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else     full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    if (sub) ov = (a[15] != b[15]) && (full[15] != a[15]);
    else     ov = (a[15] == b[15]) && (full[15] != a[15]);
    return {ov, full[16], full[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One clock: count handshakes, advance the model, then compare at negedge.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (ovalid[i] && out_ready) hs[i]++;
      if (!rst) begin
        for (int k = 0; k < 16; k++) mv[i][k] = 1'b0;
        mo[i] = '0;
      end else if (out_ready || !mv[i][ST[i]-1]) begin
        for (int k = ST[i]-1; k > 0; k--) begin
          mv[i][k] = mv[i][k-1];
          mr[i][k] = mr[i][k-1];
        end
        mv[i][0] = in_valid;
        mr[i][0] = ref_op(in_a, in_b, in_cin, in_sub);
        if (mv[i][ST[i]-1]) mo[i] = mr[i][ST[i]-1];
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out_valid[%0d]", i), 32'(ovalid[i]), 32'(mv[i][ST[i]-1]));
      chk($sformatf("out_sum[%0d]", i),   32'(osum[i]),   32'(mo[i][15:0]));
      chk($sformatf("out_cout[%0d]", i),  32'(ocout[i]),  32'(mo[i][16]));
      chk($sformatf("out_ovf[%0d]", i),   32'(oovf[i]),   32'(mo[i][17]));
      chk($sformatf("in_ready[%0d]", i),  32'(iready[i]),
          32'(out_ready || !mv[i][ST[i]-1]));
    end
  endtask

  initial begin
    int j, cyc;
    logic acc;
    hs = '{0, 0, 0};

    // reset held 3 cycles with a live operand on the input
    rst = 1'b0; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0000;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("reset_out_valid", 32'(ovalid[0]), 32'h0);
    chk("reset_out_sum", 32'(osum[0]), 32'h0);
    rst = 1'b1; in_valid = 1'b0;
    step();
    chk("release_in_ready", 32'(iready[0]), 32'h1);
    chk("release_out_valid", 32'(ovalid[0]), 32'h0);

    // carry ripple across every chunk, latency per STAGES
    lat = '{-1, -1, -1};
    in_a = 16'hFFFF; in_b = 16'h0001; in_valid = 1'b1;
    for (int e = 0; e < 20; e++) begin
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) if (ovalid[i] && lat[i] < 0) lat[i] = e;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ripple_latency[%0d]", i), 32'(lat[i]), 32'(exp_lat[i]));
      chk($sformatf("ripple_sum[%0d]", i), {14'd0, oovf[i], ocout[i], osum[i]}, 32'h0001_0000);
    end
    chk("ripple_model", {14'd0, mo[0]}, 32'h0001_0000);

    // subtract: signed overflow, then borrow
    in_a = 16'h8000; in_b = 16'h0001; in_sub = 1'b1; in_cin = 1'b0; in_valid = 1'b1;
    step();
    chk("sub_ovf_s1", {14'd0, oovf[1], ocout[1], osum[1]}, 32'h0003_7FFF);
    in_a = 16'h0000; in_b = 16'h0001; in_cin = 1'b1;
    step();
    chk("sub_borrow_s1", {14'd0, oovf[1], ocout[1], osum[1]}, 32'h0000_FFFF);
    in_valid = 1'b0; in_sub = 1'b0; in_cin = 1'b0;
    repeat (17) step();
    chk("sub_borrow_model", {14'd0, mo[2]}, 32'h0000_FFFF);

    // streaming 8 back-to-back operations
    hs = '{0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      in_a = 16'(i); in_b = 16'(i * 255); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (18) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stream_count[%0d]", i), 32'(hs[i]), 32'd8);
      chk($sformatf("stream_last[%0d]", i), 32'(osum[i]), 32'h0700);
    end

    // backpressure: out_ready low for 3 cycles mid-stream
    hs = '{0, 0, 0};
    j = 0; cyc = 0;
    while (j < 8 && cyc < 40) begin
      in_a = 16'(j); in_b = 16'(j * 255); in_valid = 1'b1;
      out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      acc = iready[0];
      if (!out_ready) chk("stall_in_ready", 32'(iready[0]), 32'h0);
      step();
      if (acc) j++;
      cyc++;
    end
    chk("bp_all_accepted", 32'(j), 32'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) step();
    chk("bp_count", 32'(hs[0]), 32'd8);
    chk("bp_last", 32'(osum[0]), 32'h0700);

    // reset with 3 operations in flight
    for (int i = 0; i < 3; i++) begin
      in_a = 16'h1000 + 16'(i); in_b = 16'h0101; in_valid = 1'b1;
      step();
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) chk($sformatf("midreset_valid[%0d]", i), 32'(ovalid[i]), 32'h0);
    rst = 1'b1; in_valid = 1'b0;
    hs = '{0, 0, 0};
    repeat (20) step();
    for (int i = 0; i < 3; i++) chk($sformatf("midreset_no_output[%0d]", i), 32'(hs[i]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
